// File: rtl/vec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// vec_issue_ctrl
//
// Purpose:
//   Issue controller that sits between instruction fetch and the vector
//   ALU / vector register file. It accepts 16-bit vector instructions and
//   runs each VADD through a fixed sequence:
//     - read both source vectors from the register file (synchronous read),
//     - present opcode and operands to the registered ALU for one cycle,
//     - write the ALU result back to the destination register.
//   NOP retires immediately. Any other opcode is rejected with a one-cycle
//   err pulse and causes no register-file or ALU activity.
//
// Ports:
//   clk          clock, all state updates on posedge
//   rst          synchronous active-high reset
//   instr_valid  instruction present on instr
//   instr        [15:12] opcode, [11:9] dst, [8:6] src_a, [5:3] src_b,
//                [2:0] not used
//   instr_ready  block can accept an instruction this cycle
//   rf_raddr_a   register-file read address A (data returns next cycle)
//   rf_raddr_b   register-file read address B
//   rf_rdata_a   register-file read data A
//   rf_rdata_b   register-file read data B
//   alu_opcode   opcode presented to the ALU (OPC_NOP when idle)
//   alu_op_1     ALU operand 1 (zero outside the execute cycle)
//   alu_op_2     ALU operand 2 (zero outside the execute cycle)
//   alu_result   ALU result, valid one cycle after the ALU samples
//   rf_we        register-file write enable
//   rf_waddr     register-file write address
//   rf_wdata     register-file write data (zero when not writing)
//   busy         high whenever the FSM is not in IDLE
//   err          one-cycle pulse after an illegal opcode is accepted
//   instr_count  retired VADD + NOP count, wraps at 2^CNT_W
// -----------------------------------------------------------------------------
module vec_issue_ctrl #(
  parameter int          VEC_W    = 256,
  parameter int          RADDR_W  = 3,
  parameter int          CNT_W    = 16,
  parameter logic [3:0]  OPC_VADD = 4'h0,
  parameter logic [3:0]  OPC_NOP  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [15:0]        instr,
  output logic               instr_ready,
  output logic [RADDR_W-1:0] rf_raddr_a,
  output logic [RADDR_W-1:0] rf_raddr_b,
  input  logic [VEC_W-1:0]   rf_rdata_a,
  input  logic [VEC_W-1:0]   rf_rdata_b,
  output logic [3:0]         alu_opcode,
  output logic [VEC_W-1:0]   alu_op_1,
  output logic [VEC_W-1:0]   alu_op_2,
  input  logic [VEC_W-1:0]   alu_result,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [VEC_W-1:0]   rf_wdata,
  output logic               busy,
  output logic               err,
  output logic [CNT_W-1:0]   instr_count
);

  localparam int LANE_W = 16;
  localparam int LANES  = VEC_W / LANE_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_reg;
  logic [RADDR_W-1:0] dst_reg;
  logic [RADDR_W-1:0] raddr_a_reg;
  logic [RADDR_W-1:0] raddr_b_reg;
  logic [3:0]         alu_opcode_reg;
  logic               rf_we_reg;
  logic [RADDR_W-1:0] rf_waddr_reg;
  logic               err_reg;
  logic [CNT_W-1:0]   count_reg;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  logic [3:0]         instr_opc;
  logic [RADDR_W-1:0] instr_dst;
  logic [RADDR_W-1:0] instr_src_a;
  logic [RADDR_W-1:0] instr_src_b;
  logic               unused_instr_bits;

  assign instr_opc         = instr[15:12];
  assign instr_dst         = instr[9 +: RADDR_W];
  assign instr_src_a       = instr[6 +: RADDR_W];
  assign instr_src_b       = instr[3 +: RADDR_W];
  // The low three bits carry no meaning for this block.
  assign unused_instr_bits = ^instr[2:0];

  logic accept;
  logic is_vadd;
  logic is_nop;
  logic is_illegal;

  // Ready is a pure function of the registered state so fetch sees it early
  // in the cycle; it is forced low while reset is held.
  assign instr_ready = !rst && ((state_reg == IDLE) || (state_reg == WB));
  assign accept      = instr_valid && instr_ready;
  assign is_vadd     = (instr_opc == OPC_VADD);
  assign is_nop      = (instr_opc == OPC_NOP);
  assign is_illegal  = !is_vadd && !is_nop;

  // ---------------------------------------------------------------------------
  // Retirement counting
  // A VADD retires on the edge that leaves WB; a NOP retires on its accept
  // edge. Both can coincide when a NOP is taken during WB, hence +2.
  // ---------------------------------------------------------------------------
  logic             retire_vadd;
  logic             retire_nop;
  logic [CNT_W-1:0] count_inc;

  assign retire_vadd = (state_reg == WB);
  assign retire_nop  = accept && is_nop;
  assign count_inc   = CNT_W'(retire_vadd) + CNT_W'(retire_nop);

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      dst_reg        <= '0;
      raddr_a_reg    <= '0;
      raddr_b_reg    <= '0;
      alu_opcode_reg <= OPC_NOP;
      rf_we_reg      <= 1'b0;
      rf_waddr_reg   <= '0;
      err_reg        <= 1'b0;
      count_reg      <= '0;
    end else begin
      // Pulse-style outputs default low / idle each cycle.
      alu_opcode_reg <= OPC_NOP;
      rf_we_reg      <= 1'b0;
      err_reg        <= accept && is_illegal;
      count_reg      <= count_reg + count_inc;

      case (state_reg)
        // IDLE and WB share the accept path: in WB the write-back for the
        // previous VADD is already committed to the output registers, so a
        // new instruction can overwrite dst/src without disturbing it.
        IDLE, WB: begin
          if (accept && is_vadd) begin
            state_reg   <= READ;
            dst_reg     <= instr_dst;
            raddr_a_reg <= instr_src_a;
            raddr_b_reg <= instr_src_b;
          end else begin
            state_reg   <= IDLE;
          end
        end

        // Read addresses are being sampled by the register file this cycle;
        // its data appears while in EXEC.
        READ: begin
          state_reg      <= EXEC;
          alu_opcode_reg <= OPC_VADD;
        end

        // ALU samples opcode/operands at the edge leaving EXEC; its result
        // is then on alu_result throughout WB.
        EXEC: begin
          state_reg    <= WB;
          rf_we_reg    <= 1'b1;
          rf_waddr_reg <= dst_reg;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath pass-through
  // Operands are forwarded straight from the register file during EXEC and
  // held at zero otherwise, so the ALU only ever sees defined inputs.
  // Write data is the live ALU result during the write cycle only.
  // ---------------------------------------------------------------------------
  logic exec_active;
  assign exec_active = (state_reg == EXEC);

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign alu_op_1[gi*LANE_W +: LANE_W] =
        exec_active ? rf_rdata_a[gi*LANE_W +: LANE_W] : '0;
      assign alu_op_2[gi*LANE_W +: LANE_W] =
        exec_active ? rf_rdata_b[gi*LANE_W +: LANE_W] : '0;
      assign rf_wdata[gi*LANE_W +: LANE_W] =
        rf_we_reg ? alu_result[gi*LANE_W +: LANE_W] : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output mapping
  // ---------------------------------------------------------------------------
  assign rf_raddr_a  = raddr_a_reg;
  assign rf_raddr_b  = raddr_b_reg;
  assign alu_opcode  = alu_opcode_reg;
  assign rf_we       = rf_we_reg;
  assign rf_waddr    = rf_waddr_reg;
  assign busy        = (state_reg != IDLE);
  assign err         = err_reg;
  assign instr_count = count_reg;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vec_issue_ctrl
//
// Scoreboard bench for vec_issue_ctrl. Stimulus tasks push the expected
// write-back (cycle, address, data), execute-cycle and err-cycle events into
// queues when an instruction is accepted; a negedge monitor pops and compares
// whenever the DUT shows rf_we, alu_opcode == VADD or err. The bench supplies
// a synchronous-read register file and a registered lane-wise 16-bit adder
// as the ALU. Expected write data are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_vec_issue_ctrl;

  localparam int VEC_W   = 256;
  localparam int RADDR_W = 3;
  localparam int CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               instr_valid;
  logic [15:0]        instr;
  logic               instr_ready;
  logic [RADDR_W-1:0] rf_raddr_a;
  logic [RADDR_W-1:0] rf_raddr_b;
  logic [VEC_W-1:0]   rf_rdata_a;
  logic [VEC_W-1:0]   rf_rdata_b;
  logic [3:0]         alu_opcode;
  logic [VEC_W-1:0]   alu_op_1;
  logic [VEC_W-1:0]   alu_op_2;
  logic [VEC_W-1:0]   alu_result;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [VEC_W-1:0]   rf_wdata;
  logic               busy;
  logic               err;
  logic [CNT_W-1:0]   instr_count;

  vec_issue_ctrl #(
    .VEC_W   (VEC_W),
    .RADDR_W (RADDR_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .rf_raddr_a  (rf_raddr_a),
    .rf_raddr_b  (rf_raddr_b),
    .rf_rdata_a  (rf_rdata_a),
    .rf_rdata_b  (rf_rdata_b),
    .alu_opcode  (alu_opcode),
    .alu_op_1    (alu_op_1),
    .alu_op_2    (alu_op_2),
    .alu_result  (alu_result),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .busy        (busy),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Register file and ALU models
  // ---------------------------------------------------------------------------
  logic             rf_init;
  logic [VEC_W-1:0] rf_mem [8];

  always @(posedge clk) begin
    if (rf_init) begin
      for (int r = 0; r < 8; r++) rf_mem[r] <= {16{16'h3C00}};
    end else if (rf_we) begin
      rf_mem[rf_waddr] <= rf_wdata;
    end
    rf_rdata_a <= rf_mem[rf_raddr_a];
    rf_rdata_b <= rf_mem[rf_raddr_b];
  end

  always @(posedge clk) begin
    if (alu_opcode == 4'h0) begin
      for (int l = 0; l < 16; l++)
        alu_result[l*16 +: 16] <= alu_op_1[l*16 +: 16] + alu_op_2[l*16 +: 16];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int               cyc;
    logic [2:0]       waddr;
    logic [VEC_W-1:0] wdata;
  } wr_exp_t;

  wr_exp_t wq[$];
  int      exq[$];
  int      erq[$];
  wr_exp_t mon_w;
  int      mon_c;

  int checks = 0;
  int errors = 0;

  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write cyc=%0d waddr=%0d wdata=%h", cyc, rf_waddr, rf_wdata);
      end else begin
        mon_w = wq.pop_front();
        if (mon_w.cyc != cyc || mon_w.waddr != rf_waddr || mon_w.wdata !== rf_wdata) begin
          errors++;
          $display("FAIL write got cyc=%0d waddr=%0d wdata=%h want cyc=%0d waddr=%0d wdata=%h",
                   cyc, rf_waddr, rf_wdata, mon_w.cyc, mon_w.waddr, mon_w.wdata);
        end else begin
          $display("write ok cyc=%0d waddr=%0d wdata=%h", cyc, rf_waddr, rf_wdata);
        end
      end
    end
    if (alu_opcode == 4'h0) begin
      checks++;
      if (exq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_exec cyc=%0d", cyc);
      end else begin
        mon_c = exq.pop_front();
        if (mon_c != cyc) begin
          errors++;
          $display("FAIL exec_cycle got=%0d want=%0d", cyc, mon_c);
        end
      end
    end else begin
      checks++;
      if (alu_op_1 != '0 || alu_op_2 != '0) begin
        errors++;
        $display("FAIL idle_operands cyc=%0d got op1=%h op2=%h want zero", cyc, alu_op_1, alu_op_2);
      end
    end
    if (err) begin
      checks++;
      if (erq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_err cyc=%0d", cyc);
      end else begin
        mon_c = erq.pop_front();
        if (mon_c != cyc) begin
          errors++;
          $display("FAIL err_cycle got=%0d want=%0d", cyc, mon_c);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic chkv(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents ins until accepted (bounded), records the negedge cycle before
  // the accept edge in acc and pushes the expected events. instr_valid is
  // left high so a following call forms a back-to-back stream.
  task automatic issue(input logic [15:0] ins, input bit wr, input logic [2:0] wa,
                       input logic [VEC_W-1:0] wd, input bit ex, input bit er,
                       output int acc);
    int guard;
    wr_exp_t e;
    guard = 0;
    acc = -1;
    instr_valid = 1'b1;
    instr = ins;
    forever begin
      @(negedge clk);
      if (instr_ready) break;
      guard++;
      if (guard > 20) break;
    end
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout instr=%h", ins);
    end else begin
      acc = cyc;
      if (wr) begin
        e.cyc = cyc + 3;
        e.waddr = wa;
        e.wdata = wd;
        wq.push_back(e);
      end
      if (ex) exq.push_back(cyc + 2);
      if (er) erq.push_back(cyc + 1);
      $display("issue instr=%h accept_cyc=%0d", ins, cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  int a0, a1, a2, a3, a4, a5, a6, a7;

  initial begin
    rf_init = 1'b1;
    instr_valid = 1'b0;
    instr = 16'h0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_during_rst", int'(instr_ready), 0);
    rf_init = 1'b0;
    rst = 1'b0;
    #1;
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_alu_opcode", int'(alu_opcode), 15);
    chk("reset_rf_we", int'(rf_we), 0);
    chk("reset_count", int'(instr_count), 0);
    chk("reset_err", int'(err), 0);
    chkv("reset_rf_wdata", rf_wdata, '0);

    // Single VADD r1 = r1 + r0 = 3C00 + 3C00 per lane
    issue(16'h0240, 1'b1, 3'd1, {16{16'h7800}}, 1'b1, 1'b0, a0);
    instr_valid = 1'b0;
    chk("vadd_busy_in_read", int'(busy), 1);
    chk("vadd_raddr_a", int'(rf_raddr_a), 1);
    wait_cycles(4);
    chk("vadd_count", int'(instr_count), 1);

    // Two back-to-back VADDs; the second reads the r1 written by the first
    issue(16'h0240, 1'b1, 3'd1, {16{16'hB400}}, 1'b1, 1'b0, a1);
    issue(16'h0240, 1'b1, 3'd1, {16{16'hF000}}, 1'b1, 1'b0, a2);
    instr_valid = 1'b0;
    chk("b2b_spacing", a2 - a1, 3);
    wait_cycles(4);
    chk("b2b_count", int'(instr_count), 3);

    // Unsupported opcode: err pulse only
    issue(16'h5000, 1'b0, 3'd0, '0, 1'b0, 1'b1, a3);
    instr_valid = 1'b0;
    chk("illegal_busy", int'(busy), 0);
    wait_cycles(3);
    chk("illegal_count", int'(instr_count), 3);

    // VADD r2 = r0 + r0, then NOP accepted in its WB cycle
    issue(16'h0400, 1'b1, 3'd2, {16{16'h7800}}, 1'b1, 1'b0, a4);
    issue(16'hF000, 1'b0, 3'd0, '0, 1'b0, 1'b0, a5);
    instr_valid = 1'b0;
    chk("nop_in_wb_spacing", a5 - a4, 3);
    chk("nop_in_wb_count", int'(instr_count), 5);
    chk("nop_in_wb_busy", int'(busy), 0);

    // Reset while in EXEC: no write may follow
    issue(16'h0240, 1'b0, 3'd0, '0, 1'b1, 1'b0, a6);
    instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("exec_before_rst", int'(alu_opcode), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_exec_ready", int'(instr_ready), 0);
    chk("rst_exec_busy", int'(busy), 0);
    chk("rst_exec_rf_we", int'(rf_we), 0);
    chk("rst_exec_alu_opcode", int'(alu_opcode), 15);
    chkv("rst_exec_alu_op_1", alu_op_1, '0);
    chk("rst_exec_count", int'(instr_count), 0);
    chk("rst_exec_waddr", int'(rf_waddr), 0);
    chk("rst_exec_raddr_a", int'(rf_raddr_a), 0);
    wait_cycles(2);
    rst = 1'b0;
    wait_cycles(3);

    // VADD r3 = r1 + r1 (F000 + F000 wraps to E000); low bits set but ignored
    issue(16'h0649, 1'b1, 3'd3, {16{16'hE000}}, 1'b1, 1'b0, a7);
    instr_valid = 1'b0;
    wait_cycles(4);
    chk("after_rst_count", int'(instr_count), 1);

    wait_cycles(2);
    chk("write_queue_empty", wq.size(), 0);
    chk("exec_queue_empty", exq.size(), 0);
    chk("err_queue_empty", erq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout at cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
